// File: rtl/irrigation_pkg.sv
// -----------------------------------------------------------------------------
// irrigation_pkg
// Shared definitions for the irrigation scheduler slice.
//  - scheduler state enum and its encoding width
//  - default run durations, fill timeout and counter width
// Optional feature macro used elsewhere in this slice: IRRIGATION_FILL_TIMEOUT_EN
// -----------------------------------------------------------------------------
package irrigation_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 3'd0,
      ST_FILL     = 3'd1,
      ST_SPRINKLE = 3'd2,
      ST_DRIP     = 3'd3,
      ST_AGRO     = 3'd4,
      ST_FAULT    = 3'd5
   } state_e;

   localparam int          CNT_W_DEF           = 16;
   localparam int unsigned SPRINKLE_CYCLES_DEF = 1000;
   localparam int unsigned DRIP_CYCLES_DEF     = 4000;
   localparam int unsigned AGRO_CYCLES_DEF     = 500;
   localparam int unsigned FILL_TIMEOUT_DEF    = 8000;

   // True for the three timed irrigation states.
   function automatic logic is_run_state(state_e s);
      return (s == ST_SPRINKLE) || (s == ST_DRIP) || (s == ST_AGRO);
   endfunction

endpackage

// File: rtl/irrigation_timer.sv
// -----------------------------------------------------------------------------
// irrigation_timer
// Down counter with synchronous load, gated decrement and zero flag. One
// instance is shared between the irrigation run durations and the optional
// fill timeout, since only one of them is ever active at a time.
// Ports:
//   clock, reset   system clock, asynchronous active-high reset (count -> 0)
//   load, load_val load count with load_val (takes priority over dec)
//   dec            decrement by one; holds at zero
//   zero           count equals zero
// -----------------------------------------------------------------------------
module irrigation_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: a load restarts the timer, otherwise count down and
   // saturate at zero so a late dec cannot wrap around.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/irrigation_scheduler.sv
// -----------------------------------------------------------------------------
// irrigation_scheduler
// Arbitrates tank refill and three irrigation requesters (sprinkling, drip,
// agrodefensive) and drives exactly one consumer at a time for a timed run.
// Priority in IDLE: refill > agro > sprinkling/drip (round-robin).
// Ports:
//   clock, reset                 system clock, asynchronous active-high reset
//   switch                       system enable; low forces IDLE, clears fault
//   levelLow, levelFull          tank level sensors
//   reqSprinkling/reqDrip/reqAgro level-sensitive requests
//   sprinkling, drip, agrodefensiveSprinkler  actuators (Moore, registered)
//   inletValve, outletValve      tank valves
//   alarm                        fault indication
//   doneSprinkling/doneDrip/doneAgro  one-cycle pulse on completed run
//   busy                         state is neither IDLE nor FAULT
// Optional feature: define IRRIGATION_FILL_TIMEOUT_EN to fault when FILL
// lasts FILL_TIMEOUT cycles without levelFull.
// -----------------------------------------------------------------------------
module irrigation_scheduler
   import irrigation_pkg::*;
#(
   parameter int          CNT_W           = CNT_W_DEF,
   parameter int unsigned SPRINKLE_CYCLES = SPRINKLE_CYCLES_DEF,
   parameter int unsigned DRIP_CYCLES     = DRIP_CYCLES_DEF,
   parameter int unsigned AGRO_CYCLES     = AGRO_CYCLES_DEF,
   parameter int unsigned FILL_TIMEOUT    = FILL_TIMEOUT_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic switch,
   input  logic levelLow,
   input  logic levelFull,
   input  logic reqSprinkling,
   input  logic reqDrip,
   input  logic reqAgro,
   output logic sprinkling,
   output logic drip,
   output logic agrodefensiveSprinkler,
   output logic inletValve,
   output logic outletValve,
   output logic alarm,
   output logic doneSprinkling,
   output logic doneDrip,
   output logic doneAgro,
   output logic busy
);

   // Durations must fit the counter and be non-zero.
   localparam longint unsigned CNT_LIMIT = 64'd1 << CNT_W;
   if (longint'(SPRINKLE_CYCLES) < 1 || longint'(SPRINKLE_CYCLES) >= CNT_LIMIT ||
       longint'(DRIP_CYCLES)     < 1 || longint'(DRIP_CYCLES)     >= CNT_LIMIT ||
       longint'(AGRO_CYCLES)     < 1 || longint'(AGRO_CYCLES)     >= CNT_LIMIT ||
       longint'(FILL_TIMEOUT)    < 1 || longint'(FILL_TIMEOUT)    >= CNT_LIMIT) begin : g_bad_cfg
      $error("irrigation_scheduler: cycle parameters must be >= 1 and < 2**CNT_W");
   end

   state_e           state_q, state_d;
   logic             last_was_drip_q, last_was_drip_d;
   logic             sprinkling_q, sprinkling_d;
   logic             drip_q, drip_d;
   logic             agro_q, agro_d;
   logic             inlet_q, inlet_d;
   logic             outlet_q, outlet_d;
   logic             alarm_q, alarm_d;
   logic             done_spr_q, done_spr_d;
   logic             done_drip_q, done_drip_d;
   logic             done_agro_q, done_agro_d;
   logic             busy_q, busy_d;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_load_val;
   logic             tmr_dec;
   logic             tmr_zero;

   irrigation_timer #(.CNT_W(CNT_W)) u_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   // Next-state, round-robin bookkeeping and timer control. A run ends when
   // the timer is already at zero, so a loaded value of C-1 gives C cycles.
   // An aborted run leaves last_was_drip alone so that requester keeps its turn.
   always_comb begin
      state_d         = state_q;
      last_was_drip_d = last_was_drip_q;
      done_spr_d      = 1'b0;
      done_drip_d     = 1'b0;
      done_agro_d     = 1'b0;
      tmr_load        = 1'b0;
      tmr_load_val    = '0;
      tmr_dec         = 1'b0;

      if (!switch) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (levelLow) begin
                  state_d = ST_FILL;
               end else if (reqAgro) begin
                  state_d = ST_AGRO;
               end else if (reqSprinkling && reqDrip) begin
                  state_d = last_was_drip_q ? ST_SPRINKLE : ST_DRIP;
               end else if (reqSprinkling) begin
                  state_d = ST_SPRINKLE;
               end else if (reqDrip) begin
                  state_d = ST_DRIP;
               end
            end
            ST_FILL: begin
               if (levelLow && levelFull) begin
                  state_d = ST_FAULT;
               end else if (levelFull) begin
                  state_d = ST_IDLE;
`ifdef IRRIGATION_FILL_TIMEOUT_EN
               end else if (tmr_zero) begin
                  state_d = ST_FAULT;
               end else begin
                  tmr_dec = 1'b1;
`endif
               end
            end
            ST_SPRINKLE, ST_DRIP, ST_AGRO: begin
               if (levelLow) begin
                  state_d = ST_FILL;
               end else if (tmr_zero) begin
                  state_d     = ST_IDLE;
                  done_spr_d  = (state_q == ST_SPRINKLE);
                  done_drip_d = (state_q == ST_DRIP);
                  done_agro_d = (state_q == ST_AGRO);
                  if (state_q == ST_SPRINKLE) begin
                     last_was_drip_d = 1'b0;
                  end else if (state_q == ST_DRIP) begin
                     last_was_drip_d = 1'b1;
                  end
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            ST_FAULT: begin
               state_d = ST_FAULT;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Entering a timed state restarts the shared timer.
      if (state_d != state_q) begin
         case (state_d)
            ST_SPRINKLE: begin
               tmr_load     = 1'b1;
               tmr_load_val = CNT_W'(SPRINKLE_CYCLES - 1);
            end
            ST_DRIP: begin
               tmr_load     = 1'b1;
               tmr_load_val = CNT_W'(DRIP_CYCLES - 1);
            end
            ST_AGRO: begin
               tmr_load     = 1'b1;
               tmr_load_val = CNT_W'(AGRO_CYCLES - 1);
            end
`ifdef IRRIGATION_FILL_TIMEOUT_EN
            ST_FILL: begin
               tmr_load     = 1'b1;
               tmr_load_val = CNT_W'(FILL_TIMEOUT - 1);
            end
`endif
            default: begin
               tmr_load = 1'b0;
            end
         endcase
      end
   end

   // Moore outputs decoded from the next state so they register alongside it.
   always_comb begin
      sprinkling_d = (state_d == ST_SPRINKLE);
      drip_d       = (state_d == ST_DRIP);
      agro_d       = (state_d == ST_AGRO);
      inlet_d      = (state_d == ST_FILL);
      outlet_d     = is_run_state(state_d);
      alarm_d      = (state_d == ST_FAULT);
      busy_d       = (state_d != ST_IDLE) && (state_d != ST_FAULT);
   end

   // State, round-robin bit and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         last_was_drip_q <= 1'b0;
         sprinkling_q    <= 1'b0;
         drip_q          <= 1'b0;
         agro_q          <= 1'b0;
         inlet_q         <= 1'b0;
         outlet_q        <= 1'b0;
         alarm_q         <= 1'b0;
         done_spr_q      <= 1'b0;
         done_drip_q     <= 1'b0;
         done_agro_q     <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         last_was_drip_q <= last_was_drip_d;
         sprinkling_q    <= sprinkling_d;
         drip_q          <= drip_d;
         agro_q          <= agro_d;
         inlet_q         <= inlet_d;
         outlet_q        <= outlet_d;
         alarm_q         <= alarm_d;
         done_spr_q      <= done_spr_d;
         done_drip_q     <= done_drip_d;
         done_agro_q     <= done_agro_d;
         busy_q          <= busy_d;
      end
   end

   assign sprinkling             = sprinkling_q;
   assign drip                   = drip_q;
   assign agrodefensiveSprinkler = agro_q;
   assign inletValve             = inlet_q;
   assign outletValve            = outlet_q;
   assign alarm                  = alarm_q;
   assign doneSprinkling         = done_spr_q;
   assign doneDrip               = done_drip_q;
   assign doneAgro               = done_agro_q;
   assign busy                   = busy_q;

endmodule
